ks10_bus_arb: RTL and testbench

//  Backplane bus arbiter sitting directly downstream of the CPU bus port.

---
 rtl/ks10_bus_arb.sv | 141 ++++++++++++++
 tb/tb_ks10_bus_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/ks10_bus_arb.sv
// ks10_bus_arb -- KS10 backplane bus arbiter.
//   Grants the single memory/IO bus to one of three masters (console > UBA >
//   CPU, fixed priority), runs one transaction at a time (IDLE -> OWN -> DONE),
//   steers the slave ACK back to the owner and times out unanswered cycles so
//   NXM/NXD accesses still complete.
// Ports:
//   clk, rst                  clock, async active-high reset
//   {cpu,csl,uba}REQI/ADDRI/DATAI   master requests, address/flags, write data
//   {cpu,csl,uba}ACKO         per-master acknowledge (combinational in OWN)
//   busREQO/ADDRO/DATAO       latched request to slaves
//   busACKI/DATAI             slave acknowledge and read data
//   arbDATAO                  read data to all masters (0 on timeout)
//   arbOWNER                  0=none 1=CPU 2=UBA 3=console
//   busTMO                    one-cycle timeout pulse
module ks10_bus_arb #(
  parameter int TMO_CYCLES = 127
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpuREQI,
  input  logic [35:0] cpuADDRI,
  input  logic [35:0] cpuDATAI,
  output logic        cpuACKO,
  input  logic        cslREQI,
  input  logic [35:0] cslADDRI,
  input  logic [35:0] cslDATAI,
  output logic        cslACKO,
  input  logic        ubaREQI,
  input  logic [35:0] ubaADDRI,
  input  logic [35:0] ubaDATAI,
  output logic        ubaACKO,
  output logic        busREQO,
  output logic [35:0] busADDRO,
  output logic [35:0] busDATAO,
  input  logic        busACKI,
  input  logic [35:0] busDATAI,
  output logic [35:0] arbDATAO,
  output logic [1:0]  arbOWNER,
  output logic        busTMO
);

  localparam logic [1:0] ownNone = 2'd0;
  localparam logic [1:0] ownCpu  = 2'd1;
  localparam logic [1:0] ownUba  = 2'd2;
  localparam logic [1:0] ownCsl  = 2'd3;

  // Timeout fires in the OWN cycle whose index (1-based) equals TMO_CYCLES,
  // i.e. when the count of already-elapsed OWN cycles reaches TMO_CYCLES-1.
  localparam logic [7:0] tmoLimit = 8'(TMO_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, OWN, DONE} state_t;

  state_t      state, nextState;
  logic [7:0]  tmoCnt;
  logic        tmoHit;
  logic        finish;
  logic        anyReq;
  logic [1:0]  winner;
  logic [35:0] winAddr, winData;

  // Priority select of the requester sampled in IDLE.
  always_comb begin
    winner  = ownNone;
    winAddr = cpuADDRI;
    winData = cpuDATAI;
    if (cslREQI) begin
      winner  = ownCsl;
      winAddr = cslADDRI;
      winData = cslDATAI;
    end else if (ubaREQI) begin
      winner  = ownUba;
      winAddr = ubaADDRI;
      winData = ubaDATAI;
    end else if (cpuREQI) begin
      winner  = ownCpu;
    end
  end

  assign anyReq = cslREQI | ubaREQI | cpuREQI;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    tmoHit    = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: if (anyReq) nextState = OWN;
      OWN: begin
        // ACK has precedence over a coincident timeout.
        tmoHit = !busACKI && (tmoCnt >= tmoLimit);
        finish = busACKI || tmoHit;
        if (finish) nextState = DONE;
      end
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busREQO  <= 1'b0;
      busADDRO <= '0;
      busDATAO <= '0;
      arbOWNER <= ownNone;
      tmoCnt   <= '0;
    end else begin
      case (state)
        IDLE: if (anyReq) begin
          busREQO  <= 1'b1;
          busADDRO <= winAddr;
          busDATAO <= winData;
          arbOWNER <= winner;
          tmoCnt   <= '0;
        end
        OWN: begin
          if (finish) begin
            busREQO  <= 1'b0;
            arbOWNER <= ownNone;
          end
          // Saturating count; never wraps back into range.
          if (!busACKI && tmoCnt != 8'hFF) tmoCnt <= tmoCnt + 8'd1;
        end
        default: begin
          busREQO  <= 1'b0;
          arbOWNER <= ownNone;
        end
      endcase
    end
  end

  assign cpuACKO  = finish && (arbOWNER == ownCpu);
  assign ubaACKO  = finish && (arbOWNER == ownUba);
  assign cslACKO  = finish && (arbOWNER == ownCsl);
  assign busTMO   = tmoHit;
  assign arbDATAO = tmoHit ? 36'd0 : busDATAI;

endmodule

// File: tb/tb_ks10_bus_arb.sv
// Bench for ks10_bus_arb: a transaction-level model (who owns the bus, for
// how many cycles, when the turnaround happens) checked every cycle, plus
// directed scenarios with literal expectations.
module tb_ks10_bus_arb;
  localparam int TMO = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        cpuREQI = 0, cslREQI = 0, ubaREQI = 0, busACKI = 0;
  logic [35:0] cpuADDRI = 0, cpuDATAI = 0, cslADDRI = 0, cslDATAI = 0;
  logic [35:0] ubaADDRI = 0, ubaDATAI = 0, busDATAI = 0;
  logic        cpuACKO, cslACKO, ubaACKO, busREQO, busTMO;
  logic [35:0] busADDRO, busDATAO, arbDATAO;
  logic [1:0]  arbOWNER;

  int tests = 0, fails = 0;

  ks10_bus_arb #(.TMO_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .cpuREQI(cpuREQI), .cpuADDRI(cpuADDRI), .cpuDATAI(cpuDATAI), .cpuACKO(cpuACKO),
    .cslREQI(cslREQI), .cslADDRI(cslADDRI), .cslDATAI(cslDATAI), .cslACKO(cslACKO),
    .ubaREQI(ubaREQI), .ubaADDRI(ubaADDRI), .ubaDATAI(ubaDATAI), .ubaACKO(ubaACKO),
    .busREQO(busREQO), .busADDRO(busADDRO), .busDATAO(busDATAO),
    .busACKI(busACKI), .busDATAI(busDATAI), .arbDATAO(arbDATAO),
    .arbOWNER(arbOWNER), .busTMO(busTMO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: owner id (0 = bus free), cycles already spent owning, turnaround flag.
  int          mOwner = 0, mAge = 0;
  bit          mTurn = 0;
  logic [35:0] mAddr = 0, mData = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mOwner = 0; mAge = 0; mTurn = 0; mAddr = 0; mData = 0;
    end else if (mOwner != 0) begin
      if (busACKI || mAge + 1 >= TMO) begin mOwner = 0; mTurn = 1; end
      else mAge++;
    end else if (mTurn) begin
      mTurn = 0;
    end else if (cslREQI) begin
      mOwner = 3; mAge = 0; mAddr = cslADDRI; mData = cslDATAI;
    end else if (ubaREQI) begin
      mOwner = 2; mAge = 0; mAddr = ubaADDRI; mData = ubaDATAI;
    end else if (cpuREQI) begin
      mOwner = 1; mAge = 0; mAddr = cpuADDRI; mData = cpuDATAI;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      bit tmoNow, fin;
      tmoNow = (mOwner != 0) && !busACKI && (mAge + 1 >= TMO);
      fin    = (mOwner != 0) && (busACKI || tmoNow);
      chk("m.busREQO", 36'(busREQO), 36'(mOwner != 0));
      chk("m.arbOWNER", 36'(arbOWNER), 36'(mOwner));
      chk("m.cpuACKO", 36'(cpuACKO), 36'(fin && mOwner == 1));
      chk("m.ubaACKO", 36'(ubaACKO), 36'(fin && mOwner == 2));
      chk("m.cslACKO", 36'(cslACKO), 36'(fin && mOwner == 3));
      chk("m.busTMO", 36'(busTMO), 36'(tmoNow));
      chk("m.arbDATAO", arbDATAO, tmoNow ? 36'd0 : busDATAI);
      if (mOwner != 0) begin
        chk("m.busADDRO", busADDRO, mAddr);
        chk("m.busDATAO", busDATAO, mData);
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic waitOwner(input logic [1:0] exp, input string name);
    for (int i = 0; i < 12 && arbOWNER == 0; i++) tick();
    chk(name, 36'(arbOWNER), 36'(exp));
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst.busREQO", 36'(busREQO), 36'd0);
    chk("rst.arbOWNER", 36'(arbOWNER), 36'd0);
    chk("rst.busADDRO", busADDRO, 36'd0);
    chk("rst.acks", 36'({cpuACKO, cslACKO, ubaACKO, busTMO}), 36'd0);
    tick(); rst = 0;
    tick();

    // 1: CPU read, ACK in 3rd OWN cycle
    cpuREQI = 1; cpuADDRI = 36'o000000_001000; cpuDATAI = 36'o777;
    tick();
    chk("t1.busREQO", 36'(busREQO), 36'd1);
    chk("t1.busADDRO", busADDRO, 36'o000000_001000);
    tick(); tick();
    busACKI = 1; busDATAI = 36'o123456_654321;
    @(negedge clk);
    chk("t1.cpuACKO", 36'(cpuACKO), 36'd1);
    chk("t1.arbDATAO", arbDATAO, 36'o123456_654321);
    tick(); busACKI = 0; cpuREQI = 0;
    chk("t1.doneOwner", 36'(arbOWNER), 36'd0);
    chk("t1.doneAck", 36'(cpuACKO), 36'd0);
    tick(); tick();

    // 2: all three request together -> 3,2,1
    cslREQI = 1; cslADDRI = 36'o3; ubaREQI = 1; ubaADDRI = 36'o2;
    cpuREQI = 1; cpuADDRI = 36'o1;
    waitOwner(2'd3, "t2.first");
    busACKI = 1; @(negedge clk);
    chk("t2.cslACKO", 36'(cslACKO), 36'd1);
    tick(); busACKI = 0; cslREQI = 0;
    chk("t2.gap", 36'(arbOWNER), 36'd0);
    waitOwner(2'd2, "t2.second");
    chk("t2.ubaAddr", busADDRO, 36'o2);
    busACKI = 1; tick(); busACKI = 0; ubaREQI = 0;
    waitOwner(2'd1, "t2.third");
    busACKI = 1; tick(); busACKI = 0; cpuREQI = 0;
    tick(); tick();

    // 3: no ACK -> timeout in 4th OWN cycle
    cpuREQI = 1; cpuADDRI = 36'o4000; busDATAI = 36'o5555;
    tick(); tick(); tick(); tick();
    @(negedge clk);
    chk("t3.cpuACKO", 36'(cpuACKO), 36'd1);
    chk("t3.busTMO", 36'(busTMO), 36'd1);
    chk("t3.arbDATAO", arbDATAO, 36'd0);
    tick(); cpuREQI = 0;
    chk("t3.done", 36'(arbOWNER), 36'd0);
    chk("t3.tmoPulse", 36'(busTMO), 36'd0);
    tick(); tick();

    // 4: ACK coincides with timeout
    cpuREQI = 1;
    tick(); tick(); tick(); tick();
    busACKI = 1; busDATAI = 36'o1212;
    @(negedge clk);
    chk("t4.busTMO", 36'(busTMO), 36'd0);
    chk("t4.cpuACKO", 36'(cpuACKO), 36'd1);
    chk("t4.arbDATAO", arbDATAO, 36'o1212);
    tick(); busACKI = 0; cpuREQI = 0;
    tick(); tick();

    // 5: async reset mid-OWN
    cpuREQI = 1; cpuADDRI = 36'o6000;
    tick(); busACKI = 1; #1;
    chk("t5.preAck", 36'(cpuACKO), 36'd1);
    rst = 1; #1;
    chk("t5.busREQO", 36'(busREQO), 36'd0);
    chk("t5.arbOWNER", 36'(arbOWNER), 36'd0);
    chk("t5.cpuACKO", 36'(cpuACKO), 36'd0);
    busACKI = 0;
    tick(); rst = 0;
    waitOwner(2'd1, "t5.regrant");
    busACKI = 1; tick(); busACKI = 0; cpuREQI = 0;
    tick(); tick();

    // 6: UBA request during CPU OWN waits for DONE
    cpuREQI = 1; cpuADDRI = 36'o7070;
    tick(); ubaREQI = 1; ubaADDRI = 36'o2020;
    tick();
    chk("t6.holdOwner", 36'(arbOWNER), 36'd1);
    chk("t6.holdAddr", busADDRO, 36'o7070);
    busACKI = 1; tick(); busACKI = 0; cpuREQI = 0;
    chk("t6.done", 36'(arbOWNER), 36'd0);
    waitOwner(2'd2, "t6.uba");
    chk("t6.ubaAddr", busADDRO, 36'o2020);
    busACKI = 1; tick(); busACKI = 0; ubaREQI = 0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
endmodule
